// File: rtl/extend_pkg.sv
// Shared types for the RV32I immediate generator.
// Format codes match the decode-stage control field.
package extend_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate mux: instr[31:7] plus format to a 32-bit immediate.
// src[k-7] holds instr[k]; the sign is always instr[31].
module imm_decode
  import extend_pkg::*;
(
  input  logic [24:0]     src,
  input  logic [2:0]      control,
  output logic [XLEN-1:0] extended_src,
  output logic            illegal
);

  logic s;

  assign s = src[24];

  always_comb begin
    extended_src = '0;
    illegal      = 1'b0;
    case (control)
      IMM_I: extended_src = {{20{s}}, src[24:13]};
      IMM_S: extended_src = {{20{s}}, src[24:18], src[4:0]};
      IMM_B: extended_src = {{20{s}}, src[0], src[23:18],
                             src[4:1], 1'b0};
      IMM_J: extended_src = {{12{s}}, src[12:5], src[13],
                             src[23:14], 1'b0};
      IMM_U: extended_src = {src[24:5], 12'b0};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/extend_unit.sv
// Decode-stage immediate generator with a capture register
// for consumers one stage downstream.
module extend_unit
  import extend_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [24:0]     src,
  input  logic [2:0]      control,
  input  logic            en,
  output logic [XLEN-1:0] extended_src,
  output logic            illegal,
  output logic [XLEN-1:0] extended_src_q,
  output logic            illegal_q
);

  imm_decode u_dec (
    .src          (src),
    .control      (control),
    .extended_src (extended_src),
    .illegal      (illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      extended_src_q <= '0;
      illegal_q      <= 1'b0;
    end else if (en) begin
      extended_src_q <= extended_src;
      illegal_q      <= illegal;
    end
  end

endmodule

// File: tb/tb_extend_unit.sv
// Bench for extend_unit: vector table on the comb path, queued
// expectations for the capture register, plus reset/enable sequences.
module tb_extend_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] src;
  logic [2:0]  control;
  logic        en;
  logic [31:0] extended_src;
  logic        illegal;
  logic [31:0] extended_src_q;
  logic        illegal_q;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  ctl;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  extend_unit dut (
    .clk            (clk),
    .reset          (reset),
    .src            (src),
    .control        (control),
    .en             (en),
    .extended_src   (extended_src),
    .illegal        (illegal),
    .extended_src_q (extended_src_q),
    .illegal_q      (illegal_q)
  );

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty got %08h expected entry",
               nm, extended_src_q);
    end else begin
      checks--;
      e = sbq.pop_front();
      chk32({nm, "_q"}, extended_src_q, e.imm);
      chk1({nm, "_illq"}, illegal_q, e.ill);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] c,
                              input logic [31:0] m, input logic l);
    vec_t v;
    v.instr = i; v.ctl = c; v.imm = m; v.ill = l;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(32'h00600093, 3'b000, 32'h00000006, 1'b0));
    vecs.push_back(mk(32'hFFA00093, 3'b000, 32'hFFFFFFFA, 1'b0));
    vecs.push_back(mk(32'h7FF00093, 3'b000, 32'h000007FF, 1'b0));
    vecs.push_back(mk(32'h80000093, 3'b000, 32'hFFFFF800, 1'b0));
    vecs.push_back(mk(32'h0020A323, 3'b001, 32'h00000006, 1'b0));
    vecs.push_back(mk(32'hFE20AD23, 3'b001, 32'hFFFFFFFA, 1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 3'b001, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk(32'h00208263, 3'b010, 32'h00000004, 1'b0));
    vecs.push_back(mk(32'hFE208EE3, 3'b010, 32'hFFFFFFFC, 1'b0));
    vecs.push_back(mk(32'h80000063, 3'b010, 32'hFFFFF000, 1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 3'b010, 32'hFFFFFFFE, 1'b0));
    vecs.push_back(mk(32'h01A004EF, 3'b011, 32'h0000001A, 1'b0));
    vecs.push_back(mk(32'hFF9FF4EF, 3'b011, 32'hFFFFFFF8, 1'b0));
    vecs.push_back(mk(32'h80000000, 3'b011, 32'hFFF00000, 1'b0));
    vecs.push_back(mk(32'h01A004EF, 3'b100, 32'h01A00000, 1'b0));
    vecs.push_back(mk(32'hFFFF84EF, 3'b100, 32'hFFFF8000, 1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 3'b100, 32'hFFFFF000, 1'b0));
    vecs.push_back(mk(32'h01A004EF, 3'b101, 32'h00000000, 1'b1));
    vecs.push_back(mk(32'hFFFFFFFF, 3'b110, 32'h00000000, 1'b1));
    vecs.push_back(mk(32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1));

    reset   = 1'b1;
    en      = 1'b1;
    src     = 25'h1FFFFFF;
    control = 3'b000;
    #1;
    chk32("rst_q", extended_src_q, 32'h0);
    chk1("rst_illq", illegal_q, 1'b0);
    chk32("rst_comb", extended_src, 32'hFFFFFFFF);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      src     = vecs[i].instr[31:7];
      control = vecs[i].ctl;
      en      = 1'b1;
      #1;
      chk32($sformatf("comb%0d", i), extended_src, vecs[i].imm);
      chk1($sformatf("ill%0d", i), illegal, vecs[i].ill);
      sbq.push_back('{imm: vecs[i].imm, ill: vecs[i].ill});
      @(posedge clk);
      #1;
      pop_check($sformatf("reg%0d", i));
    end

    // capture something nonzero, then reset between edges
    @(negedge clk);
    src     = 32'hFFA00093 >> 7;
    control = 3'b000;
    @(posedge clk);
    #1;
    chk32("pre_rst_q", extended_src_q, 32'hFFFFFFFA);
    @(negedge clk);
    control = 3'b111;
    #1;
    chk1("pre_rst_ill", illegal, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk32("async_rst_q", extended_src_q, 32'h0);
    chk1("async_rst_illq", illegal_q, 1'b0);
    @(negedge clk);
    src     = 32'h00600093 >> 7;
    control = 3'b000;
    #1;
    chk32("rst_comb_live", extended_src, 32'h6);
    @(posedge clk);
    #1;
    chk32("rst_held_q", extended_src_q, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sbq.push_back('{imm: 32'h6, ill: 1'b0});
    @(posedge clk);
    #1;
    pop_check("first_cap");

    @(negedge clk);
    en      = 1'b0;
    src     = 32'hFFFF84EF >> 7;
    control = 3'b101;
    sbq.push_back('{imm: 32'h6, ill: 1'b0});
    @(posedge clk);
    #1;
    pop_check("hold1");
    chk1("hold_comb_ill", illegal, 1'b1);
    sbq.push_back('{imm: 32'h6, ill: 1'b0});
    @(posedge clk);
    #1;
    pop_check("hold2");

    @(negedge clk);
    en = 1'b1;
    sbq.push_back('{imm: 32'h0, ill: 1'b1});
    @(posedge clk);
    #1;
    pop_check("recap_ill");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/extend_unit.md
Name: extend_unit

Overview:
- RV32I immediate generator in the decode stage.
- Takes instruction bits [31:7] and a 3-bit immediate-format select.
- Produces the 32-bit sign-extended (or upper-placed) immediate combinationally, plus a registered copy for pipelined consumers.
- Also flags unsupported format codes.

Parameters:
- XLEN, 32, output data width; only 32 is supported.

Ports:
- clk  input  1  single clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset for registered outputs.
- src  input  25  instruction bits [31:7]. src[k-7] carries instr[k]; "instr[k]" below means src[k-7].
- control  input  3  immediate format select (encoding below).
- en  input  1  capture enable for registered outputs.
- extended_src  output  32  combinational immediate.
- illegal  output  1  combinational; high when control is not a defined format.
- extended_src_q  output  32  registered immediate.
- illegal_q  output  1  registered illegal flag.

Behaviour:
- Combinational path, no latency. Output changes in the same delta as src or control.
- control 000, I-type:
  - [31:12] = instr[31] replicated
  - [11:0] = instr[31:20]
- control 001, S-type:
  - [31:12] = instr[31] replicated
  - [11:5] = instr[31:25]
  - [4:0] = instr[11:7]
- control 010, B-type:
  - [31:12] = instr[31] replicated
  - [11] = instr[7]
  - [10:5] = instr[30:25]
  - [4:1] = instr[11:8]
  - [0] = 0
- control 011, J-type:
  - [31:20] = instr[31] replicated
  - [19:12] = instr[19:12]
  - [11] = instr[20]
  - [10:1] = instr[30:21]
  - [0] = 0
- control 100, U-type:
  - [31:12] = instr[31:12]
  - [11:0] = 0
  - no sign extension beyond bit 31.
- control 101, 110, 111: extended_src = 0 and illegal = 1. For codes 000–100, illegal = 0.
- Sign extension always comes from instr[31] and nothing else.
- Registered path:
  - On rising clk with en = 1, extended_src_q <= extended_src and illegal_q <= illegal.
  - With en = 0, both hold their value.
- Reset:
  - reset high asynchronously forces extended_src_q = 0 and illegal_q = 0, regardless of clk or en.
  - Deasserting reset takes effect at the next rising edge; the first capture is on the first edge with reset low and en high.
  - Reset has no effect on the combinational outputs.
- No X propagation on defined control codes. The output is fully determined by src and control.

Decomposition:
- Package extend_pkg holds:
  - enum imm_fmt_e (3-bit): IMM_I=000, IMM_S=001, IMM_B=010, IMM_J=011, IMM_U=100.
  - XLEN constant.
- One sub-module is natural: imm_decode, purely combinational. It carries the src/control to extended_src/illegal mux.
- extend_unit wraps imm_decode and adds the capture register stage.

Test Plan:
- I-type: instr 0x00600093 (addi x1,x0,6), control 000 → extended_src = 6. Instr 0xFFA00093 → 0xFFFFFFFA (−6). illegal = 0.
- S-type: instr 0x0020A323, control 001 → 6. Instr 0xFE20AD23 → −6.
- B-type: instr 0x00208263, control 010 → 4. Instr 0xFE208EE3 → −4.
- J-type, control 011:
  - instr 0x01A004EF → 26.
  - instr 0xFF9FF4EF → −8.
- U-type, control 100:
  - instr 0x01A004EF → 0x01A00000.
  - instr 0xFFFF84EF → 0xFFFF8000.
  - control 101 with any src → extended_src = 0, illegal = 1.
- Registered path:
  - Assert reset mid-run with en = 1 → extended_src_q = 0 and illegal_q = 0 immediately, before any clk edge.
  - Release reset, apply I-type 6 with en = 1 → extended_src_q = 6 after one rising edge.
  - Drop en and change src → extended_src_q holds 6.
